// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and sizing helpers for the serial sequence detector
//
// Purpose : limits, detection-mode enum and the history fill-counter width helper
//           used by seq_detector_mealy and seq_match_counter.
// Ports   : none (package).
package seq_det_pkg;

   localparam int PAT_W_MAX = 16;
   localparam int CNT_W_MAX = 32;

   typedef enum logic {
      SEQ_NONOVL = 1'b0,
      SEQ_OVL    = 1'b1
   } seq_mode_e;

   // Width of the fill counter, which must hold 0..pat_w-1.
   function automatic int fill_width(input int pat_w);
      return (pat_w <= 2) ? 1 : $clog2(pat_w);
   endfunction

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with synchronous clear
//
// Purpose : counts increment requests, holding at all-ones; clear wins over increment.
// Ports   : clk    in  1      rising-edge clock
//           rst_n  in  1      asynchronous active-low reset
//           i_clr  in  1      synchronous clear (priority over i_inc)
//           i_inc  in  1      increment request
//           o_cnt  out CNT_W  current count
module seq_match_counter
   import seq_det_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_mealy.sv
// rtl/seq_detector_mealy.sv - Mealy serial sequence detector with runtime pattern
//
// Purpose : compares the accepted serial bit stream against a PAT_W-bit pattern
//           (pattern[PAT_W-1] earliest) and flags a match combinationally in the
//           cycle the final bit is presented. Overlapping or non-overlapping mode.
// Macro   : SEQ_DET_COUNT_EN - when defined, a saturating match counter is built;
//           otherwise match_cnt is tied to 0 and cnt_clr is ignored.
// Ports   : clk        in  1      rising-edge clock
//           rst_n      in  1      asynchronous active-low reset
//           en         in  1      input qualifier, x consumed only when 1
//           x          in  1      serial data bit
//           pattern    in  PAT_W  target sequence
//           overlap    in  1      1 = overlapping, 0 = non-overlapping
//           cnt_clr    in  1      synchronous clear of match_cnt
//           z          out 1      combinational match flag
//           match_cnt  out CNT_W  saturating match count
module seq_detector_mealy
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             x,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   input  logic             cnt_clr,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int                FILL_W    = fill_width(PAT_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  r_hist;
   logic [FILL_W-1:0] r_fill;

   logic [PAT_W-1:0]  w_window;
   logic              w_full;
   logic              w_match;
   seq_mode_e         w_mode;

   // Candidate window: stored history followed by the bit on the wire now.
   // Its low PAT_W-1 bits are also the next history, which covers PAT_W=2.
   assign w_window = {r_hist, x};
   assign w_full   = (r_fill == FILL_FULL);
   assign w_mode   = seq_mode_e'(overlap);
   assign w_match  = en & w_full & (w_window == pattern);
   assign z        = w_match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (en) begin
         r_hist <= w_window[PAT_W-2:0];
         // Non-overlapping: a match consumes the whole window, so the next
         // match needs PAT_W fresh bits. The stale history is never compared
         // until fill is full again, so it is simply shifted.
         if (w_match && (w_mode == SEQ_NONOVL)) begin
            r_fill <= '0;
         end else if (!w_full) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

`ifdef SEQ_DET_COUNT_EN
   seq_match_counter #(
      .CNT_W (CNT_W)
   ) u_match_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (cnt_clr),
      .i_inc (w_match),
      .o_cnt (match_cnt)
   );
`else
   logic w_unused_cnt_clr;
   assign w_unused_cnt_clr = cnt_clr;
   assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detector_mealy.sv
// tb/tb_seq_detector_mealy.sv - scoreboard bench for seq_detector_mealy
module tb_seq_detector_mealy;

`ifdef SEQ_DET_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       x = 1'b0;
   logic       overlap = 1'b1;
   logic       cnt_clr = 1'b0;
   logic [3:0] pat4 = 4'b1001;
   logic [2:0] pat3 = 3'b111;

   logic       z_p4, z_p3, z_c2;
   logic [7:0] cnt_p4, cnt_p3;
   logic [1:0] cnt_c2;

   int n_tests = 0;
   int n_fail  = 0;
   int sel     = 0;    // 0: PAT_W=4/CNT_W=8, 1: PAT_W=3/CNT_W=8, 2: PAT_W=4/CNT_W=2
   int m_cnt   = 0;    // model match count for the observed instance

   logic q_z[$];
   int   q_cnt[$];

   always #5 clk = ~clk;

   seq_detector_mealy #(.PAT_W(4), .CNT_W(8)) u_p4 (
      .clk(clk), .rst_n(rst_n), .en(en), .x(x), .pattern(pat4), .overlap(overlap),
      .cnt_clr(cnt_clr), .z(z_p4), .match_cnt(cnt_p4));

   seq_detector_mealy #(.PAT_W(3), .CNT_W(8)) u_p3 (
      .clk(clk), .rst_n(rst_n), .en(en), .x(x), .pattern(pat3), .overlap(overlap),
      .cnt_clr(cnt_clr), .z(z_p3), .match_cnt(cnt_p3));

   seq_detector_mealy #(.PAT_W(4), .CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .en(en), .x(x), .pattern(pat4), .overlap(overlap),
      .cnt_clr(cnt_clr), .z(z_c2), .match_cnt(cnt_c2));

   function automatic logic obs_z();
      return (sel == 0) ? z_p4 : (sel == 1) ? z_p3 : z_c2;
   endfunction

   function automatic int obs_cnt();
      return (sel == 0) ? int'(cnt_p4) : (sel == 1) ? int'(cnt_p3) : int'(cnt_c2);
   endfunction

   function automatic int cnt_max();
      return (sel == 2) ? 3 : 255;
   endfunction

   // One clock of stimulus: pops the expected z, checks it mid-cycle, then
   // checks the model count one cycle later.
   task automatic step(input logic e, input logic b, input logic clr, input string tag);
      logic ez;
      int   ec;
      @(negedge clk);
      en = e; x = b; cnt_clr = clr;
      #1;
      n_tests++;
      if (q_z.size() == 0) begin
         n_fail++;
         ez = 1'b0;
         $display("FAIL %s z: scoreboard empty, z=%0b", tag, obs_z());
      end else begin
         ez = q_z.pop_front();
         if (obs_z() !== ez) begin
            n_fail++;
            $display("FAIL %s z: got %0b expected %0b (sel=%0d)", tag, obs_z(), ez, sel);
         end
      end
      if (clr)                          m_cnt = 0;
      else if (ez && m_cnt != cnt_max()) m_cnt = m_cnt + 1;
      q_cnt.push_back(COUNT_EN ? m_cnt : 0);
      @(posedge clk);
      #1;
      ec = q_cnt.pop_front();
      n_tests++;
      if (obs_cnt() !== ec) begin
         n_fail++;
         $display("FAIL %s match_cnt: got %0d expected %0d (sel=%0d)", tag, obs_cnt(), ec, sel);
      end
   endtask

   task automatic run_stream(input logic [31:0] bits, input logic [31:0] zexp, input int n,
                             input string tag);
      for (int i = n - 1; i >= 0; i--) q_z.push_back(zexp[i]);
      for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; cnt_clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_cnt = 0;
      q_z.delete();
      q_cnt.delete();
   endtask

   task automatic check_final_cnt(input int exp_matches, input string tag);
      int e;
      e = COUNT_EN ? exp_matches : 0;
      n_tests++;
      if (obs_cnt() !== e) begin
         n_fail++;
         $display("FAIL %s final match_cnt: got %0d expected %0d", tag, obs_cnt(), e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; x = 1'b1; pat4 = 4'b1111; pat3 = 3'b111;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++;
         if ({z_p4, z_p3, z_c2} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset z: got %03b expected 000", {z_p4, z_p3, z_c2});
         end
         n_tests++;
         if (cnt_p4 !== 8'd0 || cnt_p3 !== 8'd0 || cnt_c2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset match_cnt: got %0d/%0d/%0d expected 0", cnt_p4, cnt_p3, cnt_c2);
         end
      end
      pat4 = 4'b1001;
   endtask

   task automatic test_overlap();
      sel = 0; overlap = 1'b1; pat4 = 4'b1001;
      do_reset();
      run_stream(32'b1001001001, 32'b0001001001, 10, "ovl1001");
      check_final_cnt(3, "ovl1001");
   endtask

   task automatic test_nonoverlap();
      sel = 0; overlap = 1'b0; pat4 = 4'b1001;
      do_reset();
      run_stream(32'b1001001001, 32'b0001000001, 10, "novl1001");
      check_final_cnt(2, "novl1001");
   endtask

   task automatic test_back_to_back();
      sel = 1; pat3 = 3'b111;
      overlap = 1'b1;
      do_reset();
      run_stream(32'b11111, 32'b00111, 5, "ovl111");
      check_final_cnt(3, "ovl111");
      overlap = 1'b0;
      do_reset();
      run_stream(32'b11111, 32'b00100, 5, "novl111");
      check_final_cnt(1, "novl111");
   endtask

   task automatic test_en_gaps();
      logic [3:0] bits;
      sel = 0; overlap = 1'b1; pat4 = 4'b1001;
      bits = 4'b1001;
      do_reset();
      for (int i = 3; i >= 0; i--) begin
         q_z.push_back(i == 0);
         step(1'b1, bits[i], 1'b0, "gap_acc");
         if (i != 0) begin
            q_z.push_back(1'b0);
            step(1'b0, 1'($urandom_range(1)), 1'b0, "gap_idle");
         end
      end
   endtask

   task automatic test_reset_mid();
      sel = 0; overlap = 1'b1; pat4 = 4'b1001;
      do_reset();
      run_stream(32'b100, 32'b000, 3, "rst_pre");
      @(negedge clk);
      en = 1'b1; x = 1'b1;
      #1;
      n_tests++;
      if (z_p4 !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid pending z: got %0b expected 1", z_p4);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (z_p4 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid async z: got %0b expected 0", z_p4);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_cnt = 0;
      run_stream(32'b1001, 32'b0001, 4, "rst_post");
      check_final_cnt(1, "rst_post");
   endtask

   task automatic test_live_pattern();
      sel = 0; overlap = 1'b1; pat4 = 4'b1001;
      do_reset();
      run_stream(32'b101, 32'b000, 3, "live_pre");
      pat4 = 4'b1011;
      q_z.push_back(1'b1);
      step(1'b1, 1'b1, 1'b0, "live_switch");
      pat4 = 4'b1001;
   endtask

   task automatic test_saturate();
      sel = 2; overlap = 1'b1; pat4 = 4'b1001;
      do_reset();
      run_stream(32'b1001001001001, 32'b0001001001001, 13, "sat");
      check_final_cnt(3, "sat");
      q_z.push_back(1'b0); step(1'b1, 1'b0, 1'b0, "clr_a");
      q_z.push_back(1'b0); step(1'b1, 1'b0, 1'b0, "clr_b");
      q_z.push_back(1'b1); step(1'b1, 1'b1, 1'b1, "clr_match");
      check_final_cnt(0, "clr_match");
      run_stream(32'b001, 32'b001, 3, "after_clr");
      check_final_cnt(1, "after_clr");
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_back_to_back();
      test_en_gaps();
      test_reset_mid();
      test_live_pattern();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_detector_mealy.md
# seq_detector_mealy

- Parametrised overlapping/non-overlapping Mealy serial sequence detector.
- Compares a serial bit stream against a runtime-programmable PAT_W-bit pattern and asserts a same-cycle match flag.
- Keeps an optional saturating match counter.
- Sits on the serial-input side of the design and generalises the fixed 4-bit 1001 detector with runtime pattern, overlap mode and input qualifier.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, match counter width; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- en  input  1  input qualifier; x is consumed only when en=1.
- x  input  1  serial data bit.
- pattern  input  PAT_W  target sequence; pattern[PAT_W-1] is the earliest bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- z  output  1  Mealy match flag, combinational.
- match_cnt  output  CNT_W  saturating count of matches.

## Operation
- State registers:
  - hist[PAT_W-2:0]: previous accepted bits, hist[0] newest.
  - fill: number of valid history bits, 0..PAT_W-1, width clog2(PAT_W).
- Match: z = en & (fill == PAT_W-1) & ({hist, x} == pattern).
- Accepted bit (en=1) at the clock edge:
  - overlap=1, or z=0: hist <= {hist[PAT_W-3:0], x}; fill <= min(fill+1, PAT_W-1). For PAT_W=2, hist <= x.
  - overlap=0 and z=1: fill <= 0. hist content is don't-care and may shift.
- en=0: hist and fill hold; z=0.
- pattern and overlap are sampled live every cycle. Changing either with en=1 takes effect on that same cycle's compare, with no restart of history.
- Counter:
  - cnt_clr=1: match_cnt <= 0. This has priority over any same-cycle match, so that match is not counted.
  - Otherwise, z=1 and match_cnt != all-ones: match_cnt <= match_cnt+1.
  - At all-ones, match_cnt holds (saturates).
- No X propagation: z is defined whenever en, x, pattern and overlap are known.

## Timing
- Reset values: hist=0, fill=0, match_cnt=0.
- z=0 throughout reset, since fill=0 and PAT_W>=2.
- Latency: z rises in the same cycle the final pattern bit is presented with en=1, before the clock edge.
- match_cnt reflects that match one cycle later.
- First possible match: the PAT_W-th accepted bit after reset, or after a non-overlap match.
- Reset mid-stream: partial history is discarded immediately. The next match requires PAT_W fresh accepted bits.
- Boundary cases:
  - Back-to-back matches in overlap mode can occur on consecutive cycles, e.g. an all-ones pattern.
  - In non-overlap mode, matches are at least PAT_W accepted bits apart.

## Configuration
- SEQ_DET_COUNT_EN defined:
  - Counter logic is present as described.
- SEQ_DET_COUNT_EN undefined:
  - No counter registers.
  - match_cnt is tied to 0.
  - cnt_clr is ignored.
  - z and detection behaviour are unchanged.

## Structure
- seq_det_pkg holds:
  - PAT_W_MAX=16 and CNT_W_MAX=32.
  - Localparam helper for fill width (clog2).
  - Mode enum: SEQ_NONOVL=0, SEQ_OVL=1.
- One sub-module, seq_match_counter: saturating counter with sync clear and increment. It is instantiated only under SEQ_DET_COUNT_EN.
- Top level contains hist/fill registers and the compare.

## Test plan
- PAT_W=4, pattern=1001, overlap=1, en=1, stream 1,0,0,1,0,0,1,0,0,1 -> z=1 on bits 4, 7 and 10; match_cnt=3.
- Same stream with overlap=0 -> z=1 on bits 4 and 10 only; match_cnt=2.
- PAT_W=3, pattern=111, stream 1,1,1,1,1 -> overlap=1: z on bits 3, 4 and 5. overlap=0: z on bit 3 only.
- pattern=1001 with en=0 gaps inserted between every bit of 1,0,0,1 -> a single z=1 on the fourth accepted bit; z=0 in every en=0 cycle.
- Assert rst_n=0 asynchronously after accepting 1,0,0, then release and present 1 -> z=0. Then present 0,0,1 -> z=1 on the final 1.
- CNT_W=2, overlap=1, stream 1001001001001 (4 matches) -> match_cnt=3, saturated. Pulse cnt_clr coincident with a match -> match_cnt=0 next cycle. Without SEQ_DET_COUNT_EN, match_cnt=0 throughout.
